// File: rtl/syscall_ctrl.sv
// Syscall sequencer: decodes print/halt, drives the pipeline stall and paces
// buffered print values onto the LED display through a small FIFO.
module syscall_ctrl #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  input  logic        go,
  output logic        stall,
  output logic        halted,
  output logic [31:0] led_data,
  output logic [15:0] print_cnt,
  output logic        fifo_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_HALT, S_RESUME} state_e;

  state_e          state_q, state_d;
  logic            go_s1_q, go_s2_q, go_s3_q, go_rise_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     cnt_q, cnt_d;
  logic [TW-1:0]   timer_q;
  logic            full_q, halted_q;
  logic [31:0]     led_q;
  logic [15:0]     pcnt_q;
  logic [31:0]     mem_q [DEPTH];
  logic            is_print, is_halt, push, pop;

  assign is_print = syscall && (v0 == 32'd34);
  assign is_halt  = syscall && (v0 == 32'd10);
  assign pop      = (timer_q == '0) && (cnt_q != '0);

  // Fullness comes from the registered flag only, so a same-cycle pop never frees a slot.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    push    = 1'b0;
    case (state_q)
      S_RUN: begin
        if (is_halt) begin
          stall   = 1'b1;
          state_d = S_HALT;
        end else if (is_print) begin
          if (full_q) stall = 1'b1;
          else        push  = 1'b1;
        end
      end
      S_HALT: begin
        stall = 1'b1;
        if (go_rise_q) state_d = S_RESUME;
      end
      S_RESUME: state_d = S_RUN;
      default:  state_d = S_RUN;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_RUN;
      go_s1_q   <= 1'b0;
      go_s2_q   <= 1'b0;
      go_s3_q   <= 1'b0;
      go_rise_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
      full_q    <= 1'b0;
      halted_q  <= 1'b0;
      led_q     <= '0;
      pcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      go_s1_q   <= go;
      go_s2_q   <= go_s1_q;
      go_s3_q   <= go_s2_q;
      go_rise_q <= go_s2_q & ~go_s3_q;
      cnt_q     <= cnt_d;
      full_q    <= (cnt_d == FULL_CNT);
      halted_q  <= (state_d == S_HALT);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        pcnt_q   <= pcnt_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        led_q    <= mem_q[rd_ptr_q];
        timer_q  <= HOLD_LOAD;
      end else if (timer_q != '0) begin
        timer_q  <= timer_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= a0;
  end

  assign halted    = halted_q;
  assign led_data  = led_q;
  assign print_cnt = pcnt_q;
  assign fifo_full = full_q;

endmodule

// File: tb/tb_syscall_ctrl.sv
// Directed bench for syscall_ctrl: vector table for print/pacing, hand sequences for halt/go/reset.
module tb_syscall_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        syscall = 1'b0;
  logic [31:0] v0 = '0;
  logic [31:0] a0 = '0;
  logic        go = 1'b0;
  logic        stall, halted, fifo_full;
  logic [31:0] led_data;
  logic [15:0] print_cnt;

  int checks = 0;
  int errors = 0;

  syscall_ctrl #(.DEPTH(4), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .syscall(syscall), .v0(v0), .a0(a0), .go(go),
    .stall(stall), .halted(halted), .led_data(led_data),
    .print_cnt(print_cnt), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_b;
    bit          sc;
    logic [31:0] v0;
    logic [31:0] a0;
    bit          e_stall;
    logic [31:0] e_led;
    logic [15:0] e_pc;
    bit          e_full;
    bit          e_halt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit sc, int c, int a, bit st, int led, int pc, bit f, bit h);
    vec_t t;
    t.rst_b = r; t.sc = sc; t.v0 = c; t.a0 = a; t.e_stall = st;
    t.e_led = led; t.e_pc = 16'(pc); t.e_full = f; t.e_halt = h;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic idle(input int n);
    syscall = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Single print plus a no-op code
    vecs.push_back(mk(1, 1, 34, 5,  0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,  0,  0, 5, 1, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 5, 1, 0, 0));
    vecs.push_back(mk(0, 1, 7, 99,  0, 5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   0, 5, 1, 0, 0));
    for (int i = 0; i < 6; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 5, 1, 0, 0));
    // Six back-to-back prints into a 4-deep FIFO, paced 4 cycles apart
    vecs.push_back(mk(1, 1, 34, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 34, 2, 0, 1, 2, 0, 0));
    vecs.push_back(mk(0, 1, 34, 3, 0, 1, 3, 0, 0));
    vecs.push_back(mk(0, 1, 34, 4, 0, 1, 4, 0, 0));
    vecs.push_back(mk(0, 1, 34, 5, 0, 1, 5, 1, 0));
    vecs.push_back(mk(0, 1, 34, 6, 1, 2, 5, 0, 0));
    vecs.push_back(mk(0, 1, 34, 6, 0, 2, 6, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 2, 6, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 2, 6, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 3, 6, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 3, 6, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 4, 6, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 4, 6, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 5, 6, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 5, 6, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 6, 6, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 6, 6, 0, 0));

    // Reset with random inputs applied, then release
    syscall = 1'b1; v0 = $urandom; a0 = $urandom; go = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      tick();
      syscall = 1'($urandom); v0 = $urandom; a0 = $urandom;
    end
    rst = 1'b1;
    syscall = 1'b0;
    #1;
    chk("reset_stall", {31'd0, stall}, 0);
    chk("reset_halted", {31'd0, halted}, 0);
    chk("reset_led", led_data, 0);
    chk("reset_print_cnt", {16'd0, print_cnt}, 0);
    chk("reset_full", {31'd0, fifo_full}, 0);
    tick();

    foreach (vecs[i]) begin
      if (vecs[i].rst_b) do_reset();
      syscall = vecs[i].sc; v0 = vecs[i].v0; a0 = vecs[i].a0;
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
      tick();
      chk($sformatf("v%0d_led", i), led_data, vecs[i].e_led);
      chk($sformatf("v%0d_print_cnt", i), {16'd0, print_cnt}, {16'd0, vecs[i].e_pc});
      chk($sformatf("v%0d_full", i), {31'd0, fifo_full}, {31'd0, vecs[i].e_full});
      chk($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].e_halt});
    end

    // go pulsed in RUN is discarded; a later halt must not resume on the stale edge
    do_reset();
    go = 1'b1; idle(3); go = 1'b0; idle(4);
    chk("go_run_halted", {31'd0, halted}, 0);
    chk("go_run_stall", {31'd0, stall}, 0);
    syscall = 1'b1; v0 = 32'd10;
    #1;
    chk("halt_decode_stall", {31'd0, stall}, 1);
    chk("halt_decode_halted", {31'd0, halted}, 0);
    tick();
    chk("halt_entered", {31'd0, halted}, 1);
    chk("halt_stall", {31'd0, stall}, 1);
    for (int i = 0; i < 6; i++) tick();
    chk("halt_no_stale_go", {31'd0, halted}, 1);

    // go high for 3 cycles: sampled at M, M+1, M+2; RESUME after M+3
    go = 1'b1;
    tick();
    tick();
    chk("halt_m1", {31'd0, halted}, 1);
    tick();
    go = 1'b0;
    chk("halt_m2", {31'd0, halted}, 1);
    tick();
    chk("resume_halted", {31'd0, halted}, 0);
    chk("resume_stall", {31'd0, stall}, 0);
    tick();
    syscall = 1'b0;
    #1;
    chk("run_after_resume_stall", {31'd0, stall}, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("run_no_rehalt", {31'd0, halted}, 0);

    // Reset during HALT with a value still queued
    do_reset();
    syscall = 1'b1; v0 = 32'd34; a0 = 32'd11; tick();
    a0 = 32'd12; tick();
    chk("pre_halt_led", led_data, 11);
    v0 = 32'd10; tick();
    chk("pre_rst_halted", {31'd0, halted}, 1);
    tick();
    rst = 1'b0; syscall = 1'b0;
    #1;
    chk("rst_halt_halted", {31'd0, halted}, 0);
    chk("rst_halt_stall", {31'd0, stall}, 0);
    chk("rst_halt_led", led_data, 0);
    chk("rst_halt_cnt", {16'd0, print_cnt}, 0);
    tick();
    rst = 1'b1;
    idle(8);
    chk("rst_fifo_cleared", led_data, 0);
    chk("rst_still_run", {31'd0, halted}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/syscall_ctrl.md
# syscall_ctrl

Syscall sequencer for the single-cycle CPU. It decodes the active syscall from `v0`/`a0` and sequences the CPU through print, halt and resume by driving the pipeline `stall`. Print values are buffered in a small FIFO and paced onto the board LED display, so back-to-back prints remain visible. The block sits between the instruction decode path (syscall flag, register file `v0`/`a0` read ports) and the LED driver.

## Interface
- `DEPTH`, 4: print FIFO entries; power of two, at least 2.
- `HOLD_CYCLES`, 4: minimum clock cycles each printed value stays on `led_data` before the next one loads; at least 1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `syscall`  in  1  current instruction is a syscall; held while `stall`=1.
- `v0`  in  32  syscall code.
- `a0`  in  32  syscall argument.
- `go`  in  1  resume button, asynchronous to `clk`.
- `stall`  out  1  freeze PC/pipeline; combinational.
- `halted`  out  1  CPU is in halt; registered.
- `led_data`  out  32  value shown on the LEDs; registered.
- `print_cnt`  out  16  number of print syscalls accepted; registered.
- `fifo_full`  out  1  print FIFO holds `DEPTH` entries; registered count compare.

## Operation
- Syscall codes:
  - 34 = print `a0`.
  - 10 = halt.
  - Any other code retires as a no-op: no stall, no push.
- FSM states:
  - RUN:
    - `syscall`=1, `v0`=34, FIFO not full: push `a0`, increment `print_cnt` (wraps 0xFFFF→0), `stall`=0, stay in RUN.
    - `syscall`=1, `v0`=34, FIFO full: `stall`=1, no push, stay in RUN.
    - `syscall`=1, `v0`=10: `stall`=1, next state HALT.
  - HALT: `stall`=1, `halted`=1. A rising edge on the synchronized `go` moves to RESUME.
  - RESUME: lasts exactly one cycle. `stall`=0, `halted`=0. The `syscall` input is ignored so the halt instruction retires without re-halting. Next state RUN.
- `go` handling:
  - `go` passes through a two-flop synchronizer, then a rising-edge detector.
  - Edges seen outside HALT are discarded.
  - `go` must be held high for at least 2 `clk` cycles to be detected.
- Fullness rule: full is evaluated from the registered count only. A push is refused when full even if a pop occurs in the same cycle.
- Display pacing (independent of the FSM):
  - A hold timer counts down to 0.
  - When the timer is 0 and the FIFO is non-empty: pop the head into `led_data` and load the timer with `HOLD_CYCLES`-1.
  - `led_data` keeps its last value indefinitely when the FIFO is empty.
  - Draining continues in every FSM state, including HALT.
- FIFO: read/write pointers of log2(`DEPTH`) bits wrap naturally; an occupancy counter of log2(`DEPTH`)+1 bits; simultaneous push and pop leaves the count unchanged.

## Timing
- Reset (`rst`=0, asynchronous):
  - State RUN; FIFO empty; timer 0; synchronizer and edge registers 0.
  - `led_data`=0, `print_cnt`=0, `halted`=0, `fifo_full`=0.
  - `stall` is then 0 unless the current inputs demand it.
  - Reset during HALT releases the CPU immediately.
- `stall` depends combinationally on state, `syscall`, `v0` and the registered full flag, in the same cycle.
- A push at edge N is visible on `led_data` after edge N+1 if the timer is 0 at that edge.
- Consecutive values load at intervals of exactly `HOLD_CYCLES` edges while the FIFO stays non-empty.
- `go` high sampled at edge M:
  - HALT→RESUME occurs at edge M+3 (two sync stages plus edge detect).
  - RESUME→RUN at edge M+4.
  - `halted` falls at edge M+3.
- `halted` rises on the edge that enters HALT. `stall` is already 1 in the cycle the halt syscall is decoded.

## Test plan
- Reset with random inputs, then release → all outputs 0 and `stall`=0 while `syscall`=0.
- `v0`=34, `a0`=5, `syscall` high for 1 cycle → `stall`=0, `led_data`=5 one edge after the push, `print_cnt`=1.
- 6 consecutive print syscalls with `a0`=1..6, `DEPTH`=4, `HOLD_CYCLES`=4:
  - `stall` is high while `fifo_full`=1.
  - All 6 values appear on `led_data` in order, 4 cycles apart.
  - `print_cnt` ends at 6.
- `v0`=10 with `syscall` held high → `stall`=1 in the decode cycle, `halted`=1 next edge.
- Continuing the halt case, `go` high for 3 cycles → RESUME with `stall`=0 for exactly one cycle while `syscall` is still 1, then RUN with no re-halt.
- Three mis-timed or ignored events:
  - `go` pulsed while in RUN → ignored.
  - `v0`=7 with `syscall`=1 → no stall, no push.
  - `rst` asserted during HALT → `halted`=0 and `stall`=0 asynchronously; FIFO cleared.
